ldst_pipe: RTL

Parametrised load/store execution unit for the RV32 out-of-order core. It sits between the load/store reservation station and the data memory / store buffer, and adds the following:
- RV32 byte/half/word access sizes with sign or zero extension.
- Store byte enables.
- Misalignment detection.
- Flush of in-flight loads.
- A configurable data-memory read latency with fully pipelined loads.

---
 rtl/ldst_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ldst_pipe.sv
// ldst_pipe: RV32 load/store execution unit.
// Loads travel through a DMEM_LAT-deep shift pipeline that matches the data
// memory read latency, then get lane-selected and extended. Stores are fully
// combinational: address, byte enables and lane-replicated data are produced
// in the issue cycle and no store state is kept.
module ldst_pipe #(
    parameter int ADDR_W   = 32,
    parameter int TAG_W    = 6,
    parameter int DMEM_LAT = 1,
    parameter int FWD_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_is_st,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_rs1,
    input  logic [31:0]       i_rs2,
    input  logic [31:0]       i_imm,
    input  logic [TAG_W-1:0]  i_rrftag,
    output logic              o_dmem_req,
    output logic [ADDR_W-1:0] o_ld_addr,
    input  logic              i_stbuf_addr_hit,
    input  logic [31:0]       i_stbuf_rd_data,
    input  logic [31:0]       i_dmem_rd_data,
    output logic              o_ld_valid,
    output logic [TAG_W-1:0]  o_ld_rrftag,
    output logic [31:0]       o_ld_res,
    output logic              o_ld_misalign,
    input  logic              i_stbuf_full,
    output logic              o_st_valid,
    output logic [ADDR_W-1:0] o_st_addr,
    output logic [31:0]       o_st_data,
    output logic [3:0]        o_st_be,
    output logic              o_st_misalign,
    output logic [TAG_W-1:0]  o_st_rrftag
);

    localparam int LAST = DMEM_LAT - 1;

    // Access size code: 0 = byte, 1 = half, 2 = word. Unused load encodings fall to word.
    function automatic logic [1:0] acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        return ((sz == 2'd1) && off[0]) || ((sz == 2'd2) && (off != 2'b00));
    endfunction

    // Lane select plus sign/zero extension of a finished load.
    function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        sh_b = w >> {off, 3'b000};
        sh_h = w >> {off[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{sh_b[7]}}, sh_b[7:0]};
            3'b100:  return {24'h0, sh_b[7:0]};
            3'b001:  return {{16{sh_h[15]}}, sh_h[15:0]};
            3'b101:  return {16'h0, sh_h[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] st_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] st_lane(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    logic [ADDR_W-1:0] ea;
    logic [1:0]        off;
    logic [1:0]        sz;
    logic              mis;
    logic              acc;
    logic              vld_d;
    logic              hit_d;

    logic [DMEM_LAT-1:0] vld_q;
    logic [DMEM_LAT-1:0] mis_q;
    logic [DMEM_LAT-1:0] hit_q;
    logic [TAG_W-1:0]    tag_q [DMEM_LAT];
    logic [2:0]          f3_q  [DMEM_LAT];
    logic [1:0]          off_q [DMEM_LAT];
    logic [31:0]         fwd_q [DMEM_LAT];

    logic        ld_fin;
    logic [31:0] ld_word;

    assign ea  = ADDR_W'(i_rs1 + i_imm);
    assign off = ea[1:0];
    assign sz  = acc_size(i_funct3);
    assign mis = is_misaligned(sz, off);

    assign o_ready = !(i_is_st && i_stbuf_full);
    assign acc     = i_valid && o_ready && !i_flush;

    assign vld_d = acc && !i_is_st;
    assign hit_d = i_stbuf_addr_hit && (FWD_EN != 0) && !mis;

    assign o_dmem_req = vld_d && !mis;
    assign o_ld_addr  = {ea[ADDR_W-1:2], 2'b00};

    assign o_st_addr     = {ea[ADDR_W-1:2], 2'b00};
    assign o_st_valid    = acc && i_is_st && !mis;
    assign o_st_misalign = acc && i_is_st && mis;
    assign o_st_rrftag   = i_rrftag;
    assign o_st_be       = st_be(sz, off);
    assign o_st_data     = st_lane(sz, i_rs2);

    // Load pipeline: stage 0 captures the issue, later stages shift; flush kills all valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            mis_q <= '0;
            hit_q <= '0;
            for (int i = 0; i < DMEM_LAT; i++) begin
                tag_q[i] <= '0;
                f3_q[i]  <= '0;
                off_q[i] <= '0;
                fwd_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld_d;
            mis_q[0] <= mis;
            hit_q[0] <= hit_d;
            tag_q[0] <= i_rrftag;
            f3_q[0]  <= i_funct3;
            off_q[0] <= off;
            fwd_q[0] <= i_stbuf_rd_data;
            for (int i = 1; i < DMEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1] && !i_flush;
                mis_q[i] <= mis_q[i-1];
                hit_q[i] <= hit_q[i-1];
                tag_q[i] <= tag_q[i-1];
                f3_q[i]  <= f3_q[i-1];
                off_q[i] <= off_q[i-1];
                fwd_q[i] <= fwd_q[i-1];
            end
        end
    end

    // Finishing stage meets the memory word; all load outputs read as zero when idle.
    assign ld_fin        = vld_q[LAST] && !i_flush;
    assign ld_word       = hit_q[LAST] ? fwd_q[LAST] : i_dmem_rd_data;
    assign o_ld_valid    = ld_fin;
    assign o_ld_rrftag   = ld_fin ? tag_q[LAST] : '0;
    assign o_ld_misalign = ld_fin && mis_q[LAST];
    assign o_ld_res      = (ld_fin && !mis_q[LAST]) ? ld_extend(f3_q[LAST], off_q[LAST], ld_word) : '0;

endmodule
